wb_uart: RTL and testbench

- Wishbone-slave 8N1 UART with RX and TX FIFOs, a runtime baud/setup register, and optional RTS/CTS hardware flow control.
- Sits on the system Wishbone bus as a 4-word peripheral.
- Contains a read-sequence-armed one-shot override: after a specific register-read sequence, the next setup read returns 32'hDEADBEEF.

---
 rtl/wb_uart.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_wb_uart.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/wb_uart.sv
// Wishbone-slave 8N1 UART with RX/TX FIFOs, runtime baud setup, optional RTS/CTS
// flow control and a read-sequence-armed one-shot override of the setup readback.
module wb_uart #(
    parameter logic [30:0] INITIAL_SETUP = 31'd25,
    parameter int unsigned LGFLEN        = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic        o_wb_stall,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    input  logic        i_uart_rx,
    output logic        o_uart_tx,
    input  logic        i_cts_n,
    output logic        o_rts_n
);
    localparam int unsigned Depth = 1 << LGFLEN;
    localparam logic [LGFLEN:0] HalfFill = (LGFLEN + 1)'(Depth / 2);
    localparam logic [LGFLEN:0] RtsFill  = (LGFLEN + 1)'(Depth * 3 / 4);

    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
    typedef enum logic {TxIdle, TxBusy} tx_state_e;
    typedef enum logic [1:0] {OvIdle, OvGot1e, OvGotSetup, OvArmed} ov_state_e;

    logic req, rd, wr, setup_wr;
    logic [30:0] setup_q;
    logic [23:0] baud;
    logic unused_bits;

    assign req        = i_wb_cyc & i_wb_stb;
    assign rd         = req & ~i_wb_we;
    assign wr         = req & i_wb_we;
    assign setup_wr   = wr && (i_wb_addr == 2'd0);
    assign baud       = setup_q[23:0];
    assign o_wb_stall = 1'b0;
    assign unused_bits = ^{i_wb_sel, i_wb_data[31]};

    // FIFO storage and pointers (one extra pointer bit distinguishes full from empty)
    logic [7:0] rx_mem [Depth];
    logic [7:0] tx_mem [Depth];
    logic [LGFLEN:0] rx_wptr_q, rx_rptr_q, tx_wptr_q, tx_rptr_q, rx_fill, tx_fill;
    logic rx_empty, rx_full, tx_empty, tx_full, rx_push, rx_pop, tx_push, tx_pop;
    logic [7:0] rx_head;
    logic [15:0] rx_stat, tx_stat;

    assign rx_fill  = rx_wptr_q - rx_rptr_q;
    assign tx_fill  = tx_wptr_q - tx_rptr_q;
    assign rx_empty = (rx_fill == '0);
    assign tx_empty = (tx_fill == '0);
    assign rx_full  = rx_fill[LGFLEN];
    assign tx_full  = tx_fill[LGFLEN];
    assign rx_head  = rx_empty ? 8'h00 : rx_mem[rx_rptr_q[LGFLEN-1:0]];
    assign rx_pop   = rd && (i_wb_addr == 2'd2) && !rx_empty;
    assign tx_push  = wr && (i_wb_addr == 2'd3) && !tx_full;
    assign rx_stat  = {4'(LGFLEN), 10'(rx_fill), rx_fill >= HalfFill, ~rx_empty};
    assign tx_stat  = {4'(LGFLEN), 10'(tx_fill), tx_fill >= HalfFill, ~tx_empty};
    assign o_rts_n  = ~setup_q[30] && (rx_fill >= RtsFill);

    // FIFO memories; contents need no reset, pointers define validity
    always_ff @(posedge i_clk) begin
        if (rx_push) rx_mem[rx_wptr_q[LGFLEN-1:0]] <= rx_q_shift();
        if (tx_push) tx_mem[tx_wptr_q[LGFLEN-1:0]] <= i_wb_data[7:0];
    end

    // FIFO pointers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_wptr_q <= '0;
            rx_rptr_q <= '0;
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
        end else begin
            if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
            if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
            if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
        end
    end

    // Receiver: synchronizer plus mid-bit sampling state machine
    rx_state_e rx_state_q, rx_state_d;
    logic [23:0] rx_cnt_q, rx_cnt_d;
    logic [2:0] rx_bit_q, rx_bit_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic rx_meta_q, rx_sync_q, rx_prev_q, ovf_set, ferr_set, ovf_q, ferr_q;

    function automatic logic [7:0] rx_q_shift();
        return rx_shift_q;
    endfunction

    // Receiver next-state logic
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ovf_set    = 1'b0;
        ferr_set   = 1'b0;
        unique case (rx_state_q)
            RxIdle: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = {1'b0, baud[23:1]};
                end
            end
            RxStart: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 24'd1;
                end else if (rx_sync_q) begin
                    rx_state_d = RxIdle;  // glitch, not a real start bit
                end else begin
                    rx_state_d = RxData;
                    rx_cnt_d   = baud - 24'd1;
                    rx_bit_d   = 3'd0;
                end
            end
            RxData: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 24'd1;
                end else begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_cnt_d   = baud - 24'd1;
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            default: begin
                if (rx_cnt_q != '0) begin
                    rx_cnt_d = rx_cnt_q - 24'd1;
                end else begin
                    rx_state_d = RxIdle;
                    if (!rx_sync_q) ferr_set = 1'b1;
                    else if (rx_full) ovf_set = 1'b1;
                    else rx_push = 1'b1;
                end
            end
        endcase
    end

    // Receiver state register; a setup write restarts it
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= i_uart_rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
        if (i_reset || setup_wr) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Transmitter: shifts {stop, data} out after driving the start bit
    tx_state_e tx_state_q, tx_state_d;
    logic [23:0] tx_cnt_q, tx_cnt_d;
    logic [3:0] tx_bit_q, tx_bit_d;
    logic [8:0] tx_shift_q, tx_shift_d;
    logic tx_line_q, tx_line_d;

    assign o_uart_tx = tx_line_q;

    // Transmitter next-state logic
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_line_d  = tx_line_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            TxIdle: begin
                tx_line_d = 1'b1;
                // Hold off while a setup write restarts us so no byte is lost
                if (!tx_empty && (!i_cts_n || setup_q[30]) && !setup_wr) begin
                    tx_pop     = 1'b1;
                    tx_state_d = TxBusy;
                    tx_line_d  = 1'b0;
                    tx_shift_d = {1'b1, tx_mem[tx_rptr_q[LGFLEN-1:0]]};
                    tx_bit_d   = 4'd9;
                    tx_cnt_d   = baud - 24'd1;
                end
            end
            default: begin
                if (tx_cnt_q != '0) begin
                    tx_cnt_d = tx_cnt_q - 24'd1;
                end else if (tx_bit_q == 4'd0) begin
                    tx_state_d = TxIdle;
                end else begin
                    tx_line_d  = tx_shift_q[0];
                    tx_shift_d = {1'b1, tx_shift_q[8:1]};
                    tx_bit_d   = tx_bit_q - 4'd1;
                    tx_cnt_d   = baud - 24'd1;
                end
            end
        endcase
    end

    // Transmitter state register; a setup write restarts it
    always_ff @(posedge i_clk) begin
        if (i_reset || setup_wr) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '1;
            tx_line_q  <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_line_q  <= tx_line_d;
        end
    end

    // Override sequence: RX 0x1E, 2x SETUP, 2x FIFO status, then SETUP reads DEADBEEF once
    ov_state_e ov_state_q, ov_state_d;
    logic [1:0] setup_cnt_q, setup_cnt_d, fifo_cnt_q, fifo_cnt_d;
    logic ov_fire;

    assign ov_fire = (ov_state_q == OvArmed) && (i_wb_addr == 2'd0);

    // Override next-state logic, advanced by accepted reads only
    always_comb begin
        ov_state_d  = ov_state_q;
        setup_cnt_d = setup_cnt_q;
        fifo_cnt_d  = fifo_cnt_q;
        if (rd) begin
            unique case (ov_state_q)
                OvIdle: begin
                    if (i_wb_addr == 2'd2 && !rx_empty && rx_head == 8'h1E) ov_state_d = OvGot1e;
                end
                OvGot1e: begin
                    if (i_wb_addr != 2'd0) ov_state_d = OvIdle;
                    else if (setup_cnt_q == 2'd1) ov_state_d = OvGotSetup;
                    else setup_cnt_d = setup_cnt_q + 2'd1;
                end
                OvGotSetup: begin
                    if (i_wb_addr != 2'd1) ov_state_d = OvIdle;
                    else if (fifo_cnt_q == 2'd1) ov_state_d = OvArmed;
                    else fifo_cnt_d = fifo_cnt_q + 2'd1;
                end
                default: begin
                    if (i_wb_addr == 2'd0) ov_state_d = OvIdle;
                end
            endcase
        end
        if (ov_state_d != ov_state_q) begin
            setup_cnt_d = 2'd0;
            fifo_cnt_d  = 2'd0;
        end
    end

    // Override state register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ov_state_q  <= OvIdle;
            setup_cnt_q <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            ov_state_q  <= ov_state_d;
            setup_cnt_q <= setup_cnt_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Read data mux, sampled into o_wb_data on the accepting edge
    logic [31:0] rd_data;
    always_comb begin
        rd_data = 32'h0;
        case (i_wb_addr)
            2'd0:    rd_data = ov_fire ? 32'hDEADBEEF : {1'b0, setup_q};
            2'd1:    rd_data = {tx_stat, rx_stat};
            2'd2:    rd_data = {19'h0, ovf_q, 1'b0, ferr_q, 1'b0, rx_empty, rx_head};
            default: rd_data = {16'h0, tx_stat};
        endcase
    end

    // Bus registers, setup register and sticky receive error flags
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= 32'h0;
            setup_q   <= INITIAL_SETUP;
            ovf_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            o_wb_ack  <= req;
            o_wb_data <= rd ? rd_data : 32'h0;
            if (setup_wr) setup_q <= i_wb_data[30:0];
            if (wr && i_wb_addr == 2'd2) begin
                ovf_q  <= 1'b0;
                ferr_q <= 1'b0;
            end
            if (ovf_set)  ovf_q  <= 1'b1;
            if (ferr_set) ferr_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_uart.sv
// Directed self-checking bench for wb_uart: bus reads/writes, serial RX/TX, override, flow control.
module tb_wb_uart;
    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_wb_cyc = 1'b0, i_wb_stb = 1'b0, i_wb_we = 1'b0;
    logic [1:0]  i_wb_addr = 2'd0;
    logic [31:0] i_wb_data = 32'h0;
    logic [3:0]  i_wb_sel = 4'hF;
    logic        o_wb_stall, o_wb_ack;
    logic [31:0] o_wb_data;
    logic        i_uart_rx = 1'b1, o_uart_tx, i_cts_n = 1'b0, o_rts_n;

    int unsigned n_total = 0, n_bad = 0;

    wb_uart dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb), .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr),
        .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel), .o_wb_stall(o_wb_stall),
        .o_wb_ack(o_wb_ack), .o_wb_data(o_wb_data),
        .i_uart_rx(i_uart_rx), .o_uart_tx(o_uart_tx), .i_cts_n(i_cts_n), .o_rts_n(o_rts_n)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wb_access(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata);
        @(negedge i_clk);
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = we; i_wb_addr = addr; i_wb_data = wdata;
        @(negedge i_clk);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        check("ack", {31'h0, o_wb_ack}, 32'h1);
        rdata = o_wb_data;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        wb_access(1'b0, addr, 32'h0, d);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] data);
        logic [31:0] d;
        wb_access(1'b1, addr, data, d);
    endtask

    // 25 clocks per bit: start, data LSB first, stop
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] bits;
        bits = {stop, b, 1'b0};
        @(negedge i_clk);
        for (int i = 0; i < 10; i++) begin
            i_uart_rx = bits[i];
            repeat (25) @(negedge i_clk);
        end
        i_uart_rx = 1'b1;
    endtask

    // Waits (bounded) for the TX line to drop; returns at the first negedge it reads 0
    task automatic wait_tx_start(input string tag);
        int k;
        k = 0;
        while (o_uart_tx && k < 100) begin
            @(negedge i_clk);
            k++;
        end
        check(tag, {31'h0, o_uart_tx}, 32'h0);
    endtask

    int exp_wave [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        int cnt;
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);

        // Reset state
        check("rst_tx", {31'h0, o_uart_tx}, 32'h1);
        check("rst_ack", {31'h0, o_wb_ack}, 32'h0);
        check("rst_data", o_wb_data, 32'h0);
        check("rst_rts", {31'h0, o_rts_n}, 32'h0);
        rd_chk("setup_rst", 2'd0, 32'h0000_0019);
        rd_chk("fifo_rst", 2'd1, 32'h4000_4000);

        // Single received byte, then empty read
        send_frame(8'h1E, 1'b1);
        repeat (300) @(negedge i_clk);
        rd_chk("rx_1e", 2'd2, 32'h0000_001E);
        rd_chk("rx_empty", 2'd2, 32'h0000_0100);

        // Full override sequence fires once
        send_frame(8'h1E, 1'b1);
        repeat (50) @(negedge i_clk);
        rd_chk("ov_rx", 2'd2, 32'h0000_001E);
        rd_chk("ov_s1", 2'd0, 32'h0000_0019);
        rd_chk("ov_s2", 2'd0, 32'h0000_0019);
        rd_chk("ov_f1", 2'd1, 32'h4000_4000);
        rd_chk("ov_f2", 2'd1, 32'h4000_4000);
        rd_chk("ov_fire", 2'd0, 32'hDEAD_BEEF);
        rd_chk("ov_oneshot", 2'd0, 32'h0000_0019);

        // Broken sequence does not fire
        send_frame(8'h1E, 1'b1);
        repeat (50) @(negedge i_clk);
        rd_chk("brk_rx", 2'd2, 32'h0000_001E);
        rd_chk("brk_s1", 2'd0, 32'h0000_0019);
        rd_chk("brk_rx2", 2'd2, 32'h0000_0100);
        rd_chk("brk_s2", 2'd0, 32'h0000_0019);
        rd_chk("brk_s3", 2'd0, 32'h0000_0019);
        rd_chk("brk_f1", 2'd1, 32'h4000_4000);
        rd_chk("brk_f2", 2'd1, 32'h4000_4000);
        rd_chk("brk_last", 2'd0, 32'h0000_0019);

        // Transmit 0xA5 with CTS asserted
        wr(2'd3, 32'h0000_00A5);
        wait_tx_start("tx_start");
        cnt = 0;
        while (o_uart_tx == 1'b0 && cnt < 100) begin
            cnt++;
            @(negedge i_clk);
        end
        check("tx_start_len", cnt, 32'd25);
        repeat (12) @(negedge i_clk);
        for (int i = 1; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), {31'h0, o_uart_tx}, exp_wave[i]);
            if (i < 9) repeat (25) @(negedge i_clk);
        end
        repeat (30) @(negedge i_clk);

        // CTS deasserted with flow control enabled: line stays idle, byte waits in FIFO
        i_cts_n = 1'b1;
        wr(2'd3, 32'h0000_003C);
        cnt = 0;
        repeat (300) begin
            @(negedge i_clk);
            if (!o_uart_tx) cnt++;
        end
        check("cts_hold", cnt, 32'd0);
        rd_chk("cts_txstat", 2'd3, 32'h0000_4005);
        i_cts_n = 1'b0;
        wait_tx_start("cts_release");
        repeat (300) @(negedge i_clk);
        rd_chk("tx_drained", 2'd3, 32'h0000_4000);

        // Overfill RX: 17 bytes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) send_frame(8'h40 + 8'(i), 1'b1);
        repeat (50) @(negedge i_clk);
        check("rts_full", {31'h0, o_rts_n}, 32'h1);
        rd_chk("fifo_full", 2'd1, 32'h4000_4043);
        rd_chk("rx_ovf", 2'd2, 32'h0000_1040);
        wr(2'd2, 32'h0);
        rd_chk("rx_ovf_clr", 2'd2, 32'h0000_0041);
        check("rts_14", {31'h0, o_rts_n}, 32'h1);

        // Bad stop bit: byte discarded, frame error flagged
        send_frame(8'h77, 1'b0);
        repeat (50) @(negedge i_clk);
        rd_chk("rx_ferr", 2'd2, 32'h0000_0442);

        // Flow control disabled via setup[30]
        wr(2'd0, 32'h4000_0019);
        check("rts_off", {31'h0, o_rts_n}, 32'h0);
        rd_chk("setup_wr", 2'd0, 32'h4000_0019);
        wr(2'd0, 32'h0000_0019);
        check("rts_on", {31'h0, o_rts_n}, 32'h1);

        // Reset mid-frame
        wr(2'd3, 32'h0000_0000);
        wait_tx_start("rst_tx_start");
        repeat (40) @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
        check("midrst_tx", {31'h0, o_uart_tx}, 32'h1);
        i_reset = 1'b0;
        cnt = 0;
        repeat (300) begin
            @(negedge i_clk);
            if (!o_uart_tx) cnt++;
        end
        check("midrst_idle", cnt, 32'd0);
        rd_chk("midrst_fifo", 2'd1, 32'h4000_4000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
